mem_wb_register: RTL and testbench
==================================

Name: mem_wb_register

Overview:
- MEM/WB pipeline register pair. Captures the byte-pair selected by the MEM/WB data input multiplexor, plus writeback control.
- Keeps a one-instruction history copy (t-1) of the same fields.
- Drives the register-file write port in the WB stage.
- Feeds mem_wb_top/bot and mem_wb_tm1_top/bot back to the MEM-stage data input mux and to hazard/forwarding logic.

Parameters:
DATA_W, 8, width of each data byte lane (top, bot)
REG_ADDR_W, 5, width of register-file destination address per lane

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold all state this cycle
flush  input  1  load a bubble into the current stage
valid_in  input  1  MEM-stage instruction valid
data_top_in  input  DATA_W  mux output mem_data_out_top
data_bot_in  input  DATA_W  mux output mem_data_out_bot
wb_en_top_in  input  1  write top lane to register file
wb_en_bot_in  input  1  write bottom lane to register file
wb_addr_top_in  input  REG_ADDR_W  top-lane destination register
wb_addr_bot_in  input  REG_ADDR_W  bottom-lane destination register
mem_wb_top  output  DATA_W  current top data
mem_wb_bot  output  DATA_W  current bottom data
mem_wb_tm1_top  output  DATA_W  previous-instruction top data
mem_wb_tm1_bot  output  DATA_W  previous-instruction bottom data
wb_en_top  output  1  current top write enable, qualified by valid
wb_en_bot  output  1  current bottom write enable, qualified by valid
wb_addr_top  output  REG_ADDR_W  current top destination
wb_addr_bot  output  REG_ADDR_W  current bottom destination
wb_valid  output  1  current stage holds a valid instruction
tm1_wb_en_top  output  1  t-1 top write enable
tm1_wb_en_bot  output  1  t-1 bottom write enable
tm1_wb_addr_top  output  REG_ADDR_W  t-1 top destination
tm1_wb_addr_bot  output  REG_ADDR_W  t-1 bottom destination
tm1_valid  output  1  t-1 stage valid

Behaviour:
- One clock (clock); reset is synchronous and active-high (reset). All outputs are registered.
- Reset: every output = 0, both current and t-1 (all data, addresses, enables, valids).
- Priority each rising edge: reset > flush > stall > normal advance.
- Normal advance (stall=0, flush=0):
  - t-1 fields <= current fields (data, addr, wb_en, valid).
  - Current fields <= inputs, with wb_en_x <= wb_en_x_in & valid_in.
  - When valid_in=0, current data is forced to 0.
- Stall (stall=1, flush=0): current and t-1 hold every field. No shift.
- Flush (flush=1, regardless of stall):
  - t-1 <= current (shift occurs).
  - Current <= bubble: valid=0, wb_en=0, data=0, addr=0.
- Latency: input to current output is 1 cycle; input to tm1 output is 2 advancing cycles.
- Invariant: wb_en_x=1 implies wb_valid=1; tm1_wb_en_x=1 implies tm1_valid=1.
- A bubble shifted into t-1 makes tm1_valid=0 and tm1 enables 0. Its tm1 data is 0.
- Both lanes may target the same address. The block does not arbitrate; it passes both through unchanged.
- Reset asserted mid-stall or mid-flush: reset wins, all fields are 0 the next cycle.
- Deasserting stall resumes from the held state. No input is lost or duplicated while stall is high, provided upstream holds its outputs.

Optional Feature:
- Macro MEM_WB_RETIRE_CNT_EN.
- Defined:
  - Add output retire_count, 16 bits.
  - Increments by 1 on each edge where a normal advance loads valid_in=1.
  - Wraps 0xFFFF -> 0x0000.
  - Reset clears it to 0.
  - Does not change during stall, flush or reset.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset: assert reset 2 cycles with nonzero inputs -> all outputs 0; retire_count=0 if enabled.
2. Advance: load {top=0xA5, bot=0x3C, addr 3/4, en 1/1, valid 1}, then {0x11, 0x22, addr 5/6, valid 1} -> after edge 2: mem_wb_top=0x11, mem_wb_bot=0x22, mem_wb_tm1_top=0xA5, mem_wb_tm1_bot=0x3C, tm1_wb_addr_top=3.
3. Stall: after test 2, hold stall=1 for 3 cycles with inputs 0xFF/0xFF -> all outputs unchanged. Release -> current=0xFF/0xFF, tm1=0x11/0x22.
4. Flush with stall: current={0x11, 0x22, valid}, assert stall=1, flush=1 -> wb_valid=0, wb_en_top=0, mem_wb_top=0, tm1 = 0x11/0x22 with tm1_valid=1.
5. Invalid input: valid_in=0 with wb_en_top_in=1, data 0x77 -> wb_en_top=0, wb_valid=0, mem_wb_top=0.
6. MEM_WB_RETIRE_CNT_EN: preload the counter to 0xFFFE via 65534 valid advances, then send 3 valid advances and 1 stall -> reads 0xFFFF, 0x0000, 0x0001, holds 0x0001 during the stall.

Source files
------------

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register pair with a one-instruction history (t-1) copy.
// Captures the byte pair chosen by the MEM-stage data mux plus writeback
// control, drives the register-file write port, and feeds current and t-1
// values back to the MEM-stage data mux and hazard/forwarding logic.
// Edge priority: reset > flush > stall > normal advance.
// Optional feature: define MEM_WB_RETIRE_CNT_EN to add a 16-bit retire_count
// output that counts valid instructions loaded by normal advances.
module mem_wb_register #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     data_top_in,
  input  logic [DATA_W-1:0]     data_bot_in,
  input  logic                  wb_en_top_in,
  input  logic                  wb_en_bot_in,
  input  logic [REG_ADDR_W-1:0] wb_addr_top_in,
  input  logic [REG_ADDR_W-1:0] wb_addr_bot_in,
  output logic [DATA_W-1:0]     mem_wb_top,
  output logic [DATA_W-1:0]     mem_wb_bot,
  output logic [DATA_W-1:0]     mem_wb_tm1_top,
  output logic [DATA_W-1:0]     mem_wb_tm1_bot,
  output logic                  wb_en_top,
  output logic                  wb_en_bot,
  output logic [REG_ADDR_W-1:0] wb_addr_top,
  output logic [REG_ADDR_W-1:0] wb_addr_bot,
  output logic                  wb_valid,
  output logic                  tm1_wb_en_top,
  output logic                  tm1_wb_en_bot,
  output logic [REG_ADDR_W-1:0] tm1_wb_addr_top,
  output logic [REG_ADDR_W-1:0] tm1_wb_addr_bot,
  output logic                  tm1_valid
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [15:0]           retire_count
`endif
);

  // One pipeline slot: the same field set is used for current and t-1.
  typedef struct packed {
    logic [DATA_W-1:0]     top;
    logic [DATA_W-1:0]     bot;
    logic [REG_ADDR_W-1:0] addr_top;
    logic [REG_ADDR_W-1:0] addr_bot;
    logic                  en_top;
    logic                  en_bot;
    logic                  valid;
  } slot_t;

  slot_t cur_q, cur_d;
  slot_t tm1_q, tm1_d;
  logic  advance;

  // A normal advance only happens when neither flush nor stall is asserted.
  assign advance = !flush && !stall;

  // Next-state selection: flush shifts and inserts a bubble, stall holds,
  // otherwise shift and load the qualified MEM-stage inputs.
  always_comb begin
    cur_d = cur_q;
    tm1_d = tm1_q;
    if (flush) begin
      tm1_d = cur_q;
      cur_d = '0;
    end else if (!stall) begin
      tm1_d          = cur_q;
      cur_d.valid    = valid_in;
      cur_d.en_top   = wb_en_top_in & valid_in;
      cur_d.en_bot   = wb_en_bot_in & valid_in;
      cur_d.addr_top = wb_addr_top_in;
      cur_d.addr_bot = wb_addr_bot_in;
      cur_d.top      = valid_in ? data_top_in : '0;
      cur_d.bot      = valid_in ? data_bot_in : '0;
    end
  end

  // Pipeline state registers with synchronous reset to an all-zero bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_q <= '0;
      tm1_q <= '0;
    end else begin
      cur_q <= cur_d;
      tm1_q <= tm1_d;
    end
  end

  assign mem_wb_top      = cur_q.top;
  assign mem_wb_bot      = cur_q.bot;
  assign wb_en_top       = cur_q.en_top;
  assign wb_en_bot       = cur_q.en_bot;
  assign wb_addr_top     = cur_q.addr_top;
  assign wb_addr_bot     = cur_q.addr_bot;
  assign wb_valid        = cur_q.valid;
  assign mem_wb_tm1_top  = tm1_q.top;
  assign mem_wb_tm1_bot  = tm1_q.bot;
  assign tm1_wb_en_top   = tm1_q.en_top;
  assign tm1_wb_en_bot   = tm1_q.en_bot;
  assign tm1_wb_addr_top = tm1_q.addr_top;
  assign tm1_wb_addr_bot = tm1_q.addr_bot;
  assign tm1_valid       = tm1_q.valid;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [15:0] retire_count_q, retire_count_d;

  // Count valid instructions loaded by a normal advance; wraps naturally.
  always_comb begin
    retire_count_d = retire_count_q;
    if (advance && valid_in) begin
      retire_count_d = retire_count_q + 16'd1;
    end
  end

  // Retire counter register, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_count_q <= '0;
    end else begin
      retire_count_q <= retire_count_d;
    end
  end

  assign retire_count = retire_count_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_mem_wb_register.sv
// Self-checking bench for mem_wb_register. A bench-side model predicts each
// cycle's outputs; predictions are queued when stimulus is driven and popped
// when the registered outputs are sampled one time unit after the edge.
// Directed constant checks from the test plan run alongside the model.
module tb_mem_wb_register;

  typedef struct packed {
    logic [7:0] top;
    logic [7:0] bot;
    logic [4:0] addr_top;
    logic [4:0] addr_bot;
    logic       en_top;
    logic       en_bot;
    logic       valid;
  } slot_t;

  typedef struct packed {
    slot_t       cur;
    slot_t       tm1;
    logic [15:0] cnt;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset, stall, flush, valid_in;
  logic [7:0] data_top_in, data_bot_in;
  logic       wb_en_top_in, wb_en_bot_in;
  logic [4:0] wb_addr_top_in, wb_addr_bot_in;
  logic [7:0] mem_wb_top, mem_wb_bot, mem_wb_tm1_top, mem_wb_tm1_bot;
  logic       wb_en_top, wb_en_bot, wb_valid;
  logic [4:0] wb_addr_top, wb_addr_bot;
  logic       tm1_wb_en_top, tm1_wb_en_bot, tm1_valid;
  logic [4:0] tm1_wb_addr_top, tm1_wb_addr_bot;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [15:0] retire_count;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sbQueue[$];
  exp_t model;

  mem_wb_register #(.DATA_W(8), .REG_ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(valid_in), .data_top_in(data_top_in), .data_bot_in(data_bot_in),
    .wb_en_top_in(wb_en_top_in), .wb_en_bot_in(wb_en_bot_in),
    .wb_addr_top_in(wb_addr_top_in), .wb_addr_bot_in(wb_addr_bot_in),
    .mem_wb_top(mem_wb_top), .mem_wb_bot(mem_wb_bot),
    .mem_wb_tm1_top(mem_wb_tm1_top), .mem_wb_tm1_bot(mem_wb_tm1_bot),
    .wb_en_top(wb_en_top), .wb_en_bot(wb_en_bot),
    .wb_addr_top(wb_addr_top), .wb_addr_bot(wb_addr_bot),
    .wb_valid(wb_valid), .tm1_wb_en_top(tm1_wb_en_top), .tm1_wb_en_bot(tm1_wb_en_bot),
    .tm1_wb_addr_top(tm1_wb_addr_top), .tm1_wb_addr_bot(tm1_wb_addr_bot),
    .tm1_valid(tm1_valid)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Single comparison point: counts, asserts, reports on mismatch.
  task automatic compareVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model of one rising edge.
  function automatic exp_t stepModel(input exp_t m, input logic rst, input logic st, input logic fl,
                                     input logic v, input logic [7:0] dt, input logic [7:0] db,
                                     input logic et, input logic eb, input logic [4:0] at, input logic [4:0] ab);
    exp_t n = m;
    if (rst) begin
      n = '0;
    end else if (fl) begin
      n.tm1 = m.cur;
      n.cur = '0;
    end else if (!st) begin
      n.tm1 = m.cur;
      n.cur.valid = v;
      n.cur.en_top = v ? et : 1'b0;
      n.cur.en_bot = v ? eb : 1'b0;
      n.cur.addr_top = at;
      n.cur.addr_bot = ab;
      n.cur.top = v ? dt : 8'h00;
      n.cur.bot = v ? db : 8'h00;
      if (v) n.cnt = m.cnt + 16'd1;
    end
    return n;
  endfunction

  // Pop the oldest prediction and compare it with the sampled outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    slot_t obsCur, obsTm1;
    if (sbQueue.size() == 0) begin
      compareVal({tag, "_queue_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sbQueue.pop_front();
    obsCur = '{mem_wb_top, mem_wb_bot, wb_addr_top, wb_addr_bot, wb_en_top, wb_en_bot, wb_valid};
    obsTm1 = '{mem_wb_tm1_top, mem_wb_tm1_bot, tm1_wb_addr_top, tm1_wb_addr_bot,
               tm1_wb_en_top, tm1_wb_en_bot, tm1_valid};
    compareVal({tag, "_cur"}, 64'(obsCur), 64'(e.cur));
    compareVal({tag, "_tm1"}, 64'(obsTm1), 64'(e.tm1));
    compareVal({tag, "_inv"}, 64'(((!wb_en_top && !wb_en_bot) || wb_valid) &&
                                  ((!tm1_wb_en_top && !tm1_wb_en_bot) || tm1_valid)), 64'd1);
`ifdef MEM_WB_RETIRE_CNT_EN
    compareVal({tag, "_cnt"}, 64'(retire_count), 64'(e.cnt));
`endif
  endtask

  // Drive one cycle of inputs, queue the prediction, clock, then check.
  task automatic applyStimulus(input string tag, input logic rst, input logic st, input logic fl,
                               input logic v, input logic [7:0] dt, input logic [7:0] db,
                               input logic et, input logic eb, input logic [4:0] at, input logic [4:0] ab);
    reset = rst; stall = st; flush = fl; valid_in = v;
    data_top_in = dt; data_bot_in = db; wb_en_top_in = et; wb_en_bot_in = eb;
    wb_addr_top_in = at; wb_addr_bot_in = ab;
    model = stepModel(model, rst, st, fl, v, dt, db, et, eb, at, ab);
    sbQueue.push_back(model);
    @(posedge clock);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    model = '0;
    reset = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    data_top_in = '0; data_bot_in = '0; wb_en_top_in = 1'b0; wb_en_bot_in = 1'b0;
    wb_addr_top_in = '0; wb_addr_bot_in = '0;
    @(negedge clock);

    // Test 1: reset held two cycles with nonzero inputs.
    applyStimulus("reset1", 1, 0, 0, 1, 8'hDE, 8'hAD, 1, 1, 5'd9, 5'd10);
    applyStimulus("reset2", 1, 1, 1, 1, 8'hBE, 8'hEF, 1, 1, 5'd11, 5'd12);
    compareVal("reset_all_zero", 64'({mem_wb_top, mem_wb_bot, mem_wb_tm1_top, mem_wb_tm1_bot,
               wb_valid, tm1_valid, wb_en_top, tm1_wb_addr_top}), 64'd0);

    // Test 2: two valid advances.
    applyStimulus("adv1", 0, 0, 0, 1, 8'hA5, 8'h3C, 1, 1, 5'd3, 5'd4);
    applyStimulus("adv2", 0, 0, 0, 1, 8'h11, 8'h22, 1, 1, 5'd5, 5'd6);
    compareVal("adv2_const", 64'({mem_wb_top, mem_wb_bot, mem_wb_tm1_top, mem_wb_tm1_bot, tm1_wb_addr_top}),
               64'({8'h11, 8'h22, 8'hA5, 8'h3C, 5'd3}));

    // Test 3: stall three cycles, then release.
    for (int i = 0; i < 3; i++) applyStimulus("stall", 0, 1, 0, 1, 8'hFF, 8'hFF, 1, 0, 5'd7, 5'd8);
    compareVal("stall_hold", 64'({mem_wb_top, mem_wb_bot, mem_wb_tm1_top, wb_addr_top}),
               64'({8'h11, 8'h22, 8'hA5, 5'd5}));
    applyStimulus("release", 0, 0, 0, 1, 8'hFF, 8'hFF, 1, 0, 5'd7, 5'd8);
    compareVal("release_const", 64'({mem_wb_top, mem_wb_bot, mem_wb_tm1_top, mem_wb_tm1_bot, wb_en_bot}),
               64'({8'hFF, 8'hFF, 8'h11, 8'h22, 1'b0}));

    // Test 4: flush together with stall.
    applyStimulus("preflush", 0, 0, 0, 1, 8'h11, 8'h22, 1, 1, 5'd1, 5'd2);
    applyStimulus("flush", 0, 1, 1, 1, 8'h99, 8'h88, 1, 1, 5'd13, 5'd14);
    compareVal("flush_const", 64'({wb_valid, wb_en_top, mem_wb_top, wb_addr_top,
               mem_wb_tm1_top, mem_wb_tm1_bot, tm1_valid}),
               64'({1'b0, 1'b0, 8'h00, 5'd0, 8'h11, 8'h22, 1'b1}));
    applyStimulus("post_flush", 0, 0, 0, 1, 8'h44, 8'h55, 0, 1, 5'd15, 5'd16);
    compareVal("bubble_in_tm1", 64'({tm1_valid, tm1_wb_en_top, tm1_wb_en_bot, mem_wb_tm1_top}), 64'd0);

    // Test 5: invalid input with write enable requested.
    applyStimulus("invalid", 0, 0, 0, 0, 8'h77, 8'h66, 1, 1, 5'd17, 5'd18);
    compareVal("invalid_const", 64'({wb_en_top, wb_valid, mem_wb_top}), 64'd0);

    // Both lanes to the same register pass through unchanged.
    applyStimulus("same_addr", 0, 0, 0, 1, 8'h12, 8'h34, 1, 1, 5'd31, 5'd31);
    compareVal("same_addr_const", 64'({wb_addr_top, wb_addr_bot, wb_en_top, wb_en_bot}),
               64'({5'd31, 5'd31, 1'b1, 1'b1}));

    // Reset wins over stall and flush.
    applyStimulus("pre_rst", 0, 1, 0, 1, 8'h56, 8'h78, 1, 1, 5'd2, 5'd3);
    applyStimulus("rst_mid", 1, 1, 1, 1, 8'h56, 8'h78, 1, 1, 5'd2, 5'd3);

    // A short burst of random traffic through the model.
    for (int i = 0; i < 20; i++)
      applyStimulus("rand", 0, ($urandom_range(3) == 0), ($urandom_range(5) == 0), 1'($urandom),
                    8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom));

`ifdef MEM_WB_RETIRE_CNT_EN
    // Test 6: preload the counter to 0xFFFE, then observe the wrap.
    applyStimulus("cnt_reset", 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 5'd0, 5'd0);
    reset = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clock);
      model = stepModel(model, 0, 0, 0, 1, data_top_in, data_bot_in, wb_en_top_in, wb_en_bot_in,
                        wb_addr_top_in, wb_addr_bot_in);
    end
    #1;
    compareVal("cnt_preload", 64'(retire_count), 64'(16'hFFFE));
    applyStimulus("cnt1", 0, 0, 0, 1, 8'h01, 8'h02, 1, 1, 5'd1, 5'd2);
    compareVal("cnt_ffff", 64'(retire_count), 64'(16'hFFFF));
    applyStimulus("cnt2", 0, 0, 0, 1, 8'h03, 8'h04, 1, 1, 5'd1, 5'd2);
    compareVal("cnt_wrap", 64'(retire_count), 64'(16'h0000));
    applyStimulus("cnt3", 0, 0, 0, 1, 8'h05, 8'h06, 1, 1, 5'd1, 5'd2);
    compareVal("cnt_one", 64'(retire_count), 64'(16'h0001));
    applyStimulus("cnt_stall", 0, 1, 0, 1, 8'h07, 8'h08, 1, 1, 5'd1, 5'd2);
    compareVal("cnt_stall_hold", 64'(retire_count), 64'(16'h0001));
`endif

    compareVal("queue_drained", 64'(sbQueue.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
